score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Producer side of the 16-bit score bus that feeds the 7-seg score display.
//  Accepts line-clear events from the playfield logic and converts them to Tetris points.
//  Accumulates a 4-digit packed BCD score: score[15:12] is thousands, score[3:0] is units.
//  Adds digit-serially, one BCD digit per clock; the score output only changes on commit.
// PARAMETERS
//  NUM_DIGITS  4   BCD digits in the score; the score width is 4*NUM_DIGITS.
// PORTS
//  clk          in   1   system clock; the only clock.
//  rst          in   1   reset; synchronous, active-low.
//  game_reset   in   1   new-game pulse; clears score; high score kept.
//  clear_valid  in   1   line-clear event present.
//  clear_lines  in   3   lines cleared in the event; 0..4, values above 4 treated as 4.
//  clear_ready  out  1   high only in IDLE; the event is taken when valid and ready are both high.
//  score        out  16  committed packed-BCD score to the display.
//  score_pulse  out  1   one-cycle strobe on the cycle score updates.
//  high_score   out  16  best score (only with SCORE_HISCORE_EN; else tied to 0).
// BEHAVIOUR
//  Reset (rst==0 at posedge): all outputs are 0 except clear_ready, which is 1.
//   Reset also sets FSM=IDLE and the accumulator, carry and digit index to 0.
//  Points are held as BCD constants in the package: 0 lines=0000, 1=0004, 2=0010, 3=0030, 4=0120.
//  FSM states IDLE -> ADD -> COMMIT -> IDLE.
//   IDLE: clear_ready=1. On accept, latch points and copy score into acc.
//    Then set idx=0, carry=0 and go to ADD.
//   ADD: one digit per cycle, d = acc[idx] + pts[idx] + carry.
//    If d>9, write d-10 and set carry=1; else write d and set carry=0.
//    Advance idx; after digit NUM_DIGITS-1 go to COMMIT.
//   COMMIT: if the final carry is 1 (overflow), score=9999; else score=acc.
//    score_pulse=1 in this cycle; return to IDLE.
//  Latency: accept at edge N, then score and score_pulse valid after edge N+NUM_DIGITS+1 (N+5).
//  The score is stable during ADD; partial sums are never visible.
//  A 0-line event still runs the full sequence and pulses, with the score unchanged.
//  Saturation: once the score reaches 9999, further events keep it at 9999.
//  game_reset has priority over everything except rst.
//   In any state it sets score=0, FSM=IDLE, score_pulse=0, and the in-flight event is dropped.
//   If clear_valid is high in the same cycle, that event is not accepted.
//  If clear_valid is held high through a busy period, the event is accepted on the first cycle back in IDLE.
//   This gives at most one accept every NUM_DIGITS+2 cycles.
// CONFIGURATION
//  SCORE_HISCORE_EN defined: high_score register is updated in COMMIT.
//   The update happens when the new score exceeds high_score, with BCD compare done MSD first.
//   high_score survives game_reset and is cleared only by rst.
//  SCORE_HISCORE_EN undefined: no register is built and high_score = 16'h0000.
// STRUCTURE
//  Package tetris_pkg holds:
//   typedef bcd_t (logic [3:0]) and score_state_e {IDLE, ADD, COMMIT}.
//   Constant array LINE_POINTS[0:4] of packed BCD, and constant BCD_MAX = 16'h9999.
//  Sub-module bcd_digit_add: combinational a + b + cin -> sum and cout, for one digit.
//   It is instantiated once and muxed by idx.
// TESTING
//  1. Apply rst low for 2 cycles, then release -> score=0000, clear_ready=1, score_pulse=0.
//  2. Issue a 1-cycle event with lines=1 from 0000 -> score=0004 with pulse exactly 5 edges after accept.
//   clear_ready must be low for 5 cycles.
//  3. Make 2 events from score 0996 (1 line, then 3 lines).
//   -> 1000 after the first (full carry ripple), then 1030 after the second.
//  4. Add lines=4 to score 9950 -> score=9999 (saturated).
//   A further lines=1 event -> score stays 9999 and still pulses.
//  5. Assert game_reset during ADD while valid is held high -> score=0000 next cycle, no pulse.
//   The event is re-accepted after game_reset drops and gives 0004.
//  6. With SCORE_HISCORE_EN: reach 0120, then game_reset, then reach 0004.
//   -> high_score=0120 throughout. Without the macro, high_score=0000.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and BCD constants for the score path: FSM states, the
// line-clear point table and the saturation value.
package tetris_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        COMMIT
    } score_state_e;

    localparam logic [15:0] LINE_POINTS [0:4] = '{16'h0000, 16'h0004, 16'h0010, 16'h0030, 16'h0120};
    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Anything above a tetris scores as a tetris.
    function automatic logic [15:0] line_points(input logic [2:0] lines);
        logic [15:0] pts;
        case (lines)
            3'd0:    pts = LINE_POINTS[0];
            3'd1:    pts = LINE_POINTS[1];
            3'd2:    pts = LINE_POINTS[2];
            3'd3:    pts = LINE_POINTS[3];
            default: pts = LINE_POINTS[4];
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder: a + b + cin, with decimal carry out.
module bcd_digit_add
    import tetris_pkg::*;
(
    input  bcd_t a,
    input  bcd_t b,
    input  logic cin,
    output bcd_t sum,
    output logic cout
);

    logic [4:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (raw > 5'd9) begin
            sum  = 4'(raw - 5'd10);
            cout = 1'b1;
        end else begin
            sum  = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Packed-BCD score accumulator fed by line-clear events, added one digit per clock.
// Optional macro SCORE_HISCORE_EN builds the high-score register.
module score_keeper
    import tetris_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    game_reset,
    input  logic                    clear_valid,
    input  logic [2:0]              clear_lines,
    output logic                    clear_ready,
    output logic [4*NUM_DIGITS-1:0] score,
    output logic                    score_pulse,
    output logic [4*NUM_DIGITS-1:0] high_score
);

    localparam int W     = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [W-1:0] SAT = (W == 16) ? W'(BCD_MAX) : {NUM_DIGITS{4'h9}};

    score_state_e     state, state_n;
    logic [W-1:0]     acc;
    logic [W-1:0]     pts;
    logic             carry;
    logic [IDX_W-1:0] idx;
    bcd_t             dsum;
    logic             dcout;
    logic             last_digit;
    logic             accept;
    logic [W-1:0]     commit_val;

    assign clear_ready = (state == IDLE) && !game_reset;
    assign accept      = clear_valid && clear_ready;
    assign last_digit  = (idx == IDX_W'(NUM_DIGITS - 1));
    assign commit_val  = carry ? SAT : acc;

    // Single digit adder shared across all positions, selected by idx.
    bcd_digit_add u_digit (
        .a    (acc[{idx, 2'b00} +: 4]),
        .b    (pts[{idx, 2'b00} +: 4]),
        .cin  (carry),
        .sum  (dsum),
        .cout (dcout)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (game_reset) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_n = ADD;
                ADD:     if (last_digit) state_n = COMMIT;
                COMMIT:  state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Datapath: acc holds partial sums so score only moves on commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc         <= '0;
            pts         <= '0;
            carry       <= 1'b0;
            idx         <= '0;
            score       <= '0;
            score_pulse <= 1'b0;
        end else begin
            score_pulse <= 1'b0;
            if (game_reset) begin
                score <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            pts   <= W'(line_points(clear_lines));
                            acc   <= score;
                            idx   <= '0;
                            carry <= 1'b0;
                        end
                    end
                    ADD: begin
                        acc[{idx, 2'b00} +: 4] <= dsum;
                        carry                  <= dcout;
                        idx                    <= idx + IDX_W'(1);
                    end
                    COMMIT: begin
                        score       <= commit_val;
                        score_pulse <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SCORE_HISCORE_EN
    logic [W-1:0] high_q;

    // Decimal magnitude compare, most significant digit decides.
    function automatic logic bcd_greater(input logic [W-1:0] a, input logic [W-1:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
                gt      = (a[i*4 +: 4] > b[i*4 +: 4]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            high_q <= '0;
        end else if ((state == COMMIT) && !game_reset && bcd_greater(commit_val, high_q)) begin
            high_q <= commit_val;
        end
    end

    assign high_score = high_q;
`else
    assign high_score = '0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a decimal-arithmetic reference model.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        game_reset = 1'b0;
    logic        clear_valid = 1'b0;
    logic [2:0]  clear_lines = 3'd0;
    logic        clear_ready;
    logic [15:0] score;
    logic        score_pulse;
    logic [15:0] high_score;

    int n_vec = 0;
    int n_bad = 0;

    score_keeper #(.NUM_DIGITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .game_reset  (game_reset),
        .clear_valid (clear_valid),
        .clear_lines (clear_lines),
        .clear_ready (clear_ready),
        .score       (score),
        .score_pulse (score_pulse),
        .high_score  (high_score)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (plain decimal integers) -------------
    int m_score = 0;
    int m_hi    = 0;
    int m_busy  = 0;
    int m_pend  = 0;
    bit m_pulse = 0;
    bit m_live  = 0;

    function automatic int points_of(input int lines);
        case (lines)
            0: return 0;
            1: return 4;
            2: return 10;
            3: return 30;
            default: return 120;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_score = 0;
            m_hi    = 0;
            m_busy  = 0;
            m_pulse = 0;
            m_live  = 1;
        end else begin
            m_pulse = 0;
            if (game_reset) begin
                m_score = 0;
                m_busy  = 0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_score = (m_score + m_pend > 9999) ? 9999 : m_score + m_pend;
                    m_pulse = 1;
                    if (m_score > m_hi) m_hi = m_score;
                end
            end else if (clear_valid) begin
                m_pend = points_of(int'(clear_lines));
                m_busy = 5;
            end
        end
    end

    logic [15:0] exp_hi;
`ifdef SCORE_HISCORE_EN
    assign exp_hi = to_bcd(m_hi);
`else
    assign exp_hi = 16'h0000;
`endif

    // ---------------- per-cycle compare against the model ------------------
    always @(negedge clk) begin
        if (rst && m_live) begin
            n_vec++;
            if (score !== to_bcd(m_score)) begin
                n_bad++;
                $display("FAIL model_score t=%0t: got %h expected %h", $time, score, to_bcd(m_score));
            end
            n_vec++;
            if (score_pulse !== m_pulse) begin
                n_bad++;
                $display("FAIL model_pulse t=%0t: got %b expected %b", $time, score_pulse, m_pulse);
            end
            n_vec++;
            if (high_score !== exp_hi) begin
                n_bad++;
                $display("FAIL model_high t=%0t: got %h expected %h", $time, high_score, exp_hi);
            end
            if (!game_reset) begin
                n_vec++;
                if (clear_ready !== (m_busy == 0)) begin
                    n_bad++;
                    $display("FAIL model_ready t=%0t: got %b expected %b", $time, clear_ready, (m_busy == 0));
                end
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_pulse(output int edges);
        edges = 0;
        while (edges < 12) begin
            @(negedge clk);
            edges++;
            if (score_pulse === 1'b1) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL pulse_timeout: got no pulse expected pulse within 12 cycles");
    endtask

    task automatic add_event(input int lines);
        int e;
        @(posedge clk); #1;
        clear_valid = 1'b1;
        clear_lines = 3'(lines);
        @(posedge clk); #1;
        clear_valid = 1'b0;
        wait_pulse(e);
        check("latency", 16'(e), 16'd6);
    endtask

    task automatic pulse_game_reset();
        @(posedge clk); #1;
        game_reset = 1'b1;
        @(posedge clk); #1;
        game_reset = 1'b0;
    endtask

    initial begin
        int e;

        // 1: reset
        @(posedge clk); #1;
        check("rst_score", score, 16'h0000);
        check("rst_ready", 16'(clear_ready), 16'd1);
        check("rst_pulse", 16'(score_pulse), 16'd0);
        check("rst_high", high_score, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_score", score, 16'h0000);
        check("post_rst_ready", 16'(clear_ready), 16'd1);

        // 2: single-line event, exact timing
        @(posedge clk); #1;
        clear_valid = 1'b1;
        clear_lines = 3'd1;
        @(posedge clk); #1;
        clear_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("busy_ready", 16'(clear_ready), 16'd0);
            check("busy_pulse", 16'(score_pulse), 16'd0);
            check("busy_score", score, 16'h0000);
        end
        @(negedge clk);
        check("first_pulse", 16'(score_pulse), 16'd1);
        check("first_score", score, 16'h0004);
        check("first_ready", 16'(clear_ready), 16'd1);

        // 3: build 0996, then ripple carry to 1000 and add 30
        pulse_game_reset();
        @(negedge clk);
        check("greset_score", score, 16'h0000);
        for (int i = 0; i < 8; i++) add_event(4);
        for (int i = 0; i < 2; i++) add_event(2);
        for (int i = 0; i < 4; i++) add_event(1);
        check("score_0996", score, 16'h0996);
        add_event(1);
        check("ripple_1000", score, 16'h1000);
        add_event(3);
        check("score_1030", score, 16'h1030);
        add_event(0);
        check("zero_lines", score, 16'h1030);

        // 4: climb to 9950 (lines=7 scores as a tetris), then saturate
        for (int i = 0; i < 74; i++) add_event((i % 3 == 0) ? 7 : 4);
        add_event(3);
        add_event(2);
        check("score_9950", score, 16'h9950);
        add_event(4);
        check("sat_9999", score, 16'h9999);
        add_event(1);
        check("stay_9999", score, 16'h9999);

        // 5: game_reset mid-ADD with valid held high
        @(posedge clk); #1;
        clear_valid = 1'b1;
        clear_lines = 3'd1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        game_reset = 1'b1;
        @(posedge clk); #1;
        game_reset = 1'b0;
        @(negedge clk);
        check("gr_mid_score", score, 16'h0000);
        check("gr_mid_pulse", 16'(score_pulse), 16'd0);
        @(posedge clk); #1;
        clear_valid = 1'b0;
        wait_pulse(e);
        check("reaccept_lat", 16'(e), 16'd6);
        check("reaccept_score", score, 16'h0004);

        // 6: high score across game_reset, after a fresh rst
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst2_high", high_score, 16'h0000);
        add_event(4);
        check("hs_score_0120", score, 16'h0120);
`ifdef SCORE_HISCORE_EN
        check("hs_after_0120", high_score, 16'h0120);
`else
        check("hs_after_0120", high_score, 16'h0000);
`endif
        pulse_game_reset();
        add_event(1);
        check("hs_score_0004", score, 16'h0004);
`ifdef SCORE_HISCORE_EN
        check("hs_kept", high_score, 16'h0120);
`else
        check("hs_kept", high_score, 16'h0000);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
